gem_roll_to_csc_wg_lut_mch: RTL and testbench

- Parametrised, multi-channel GEM-roll → CSC wiregroup-window lookup table. Holds four tables: odd_low, odd_high, even_low, even_high.
- Serves NCH cluster lookups per clock in parallel, with a pipelined valid.
- Has a VME-side write/readback port and a self-initialising default-load FSM. Runs after reset or on software request.
- Sits between the GEM cluster sorter and the GEM-CSC wiregroup-match logic.

---
 rtl/gem_roll_to_csc_wg_lut_mch.sv | 137 +++++++++++++
 tb/tb_gem_roll_to_csc_wg_lut_mch.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gem_roll_to_csc_wg_lut_mch.sv
// rtl/gem_roll_to_csc_wg_lut_mch.sv - GEM roll to CSC wiregroup window LUT, multi-channel
// Four programmable tables with a default-load FSM and an NCH-wide two-stage lookup pipeline.
module gem_roll_to_csc_wg_lut_mch #(
  parameter int ROLLW = 3,
  parameter int WGW   = 7,
  parameter int NCH   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 reload,
  output logic                 busy,
  input  logic                 wen,
  input  logic [1:0]           w_sel,
  input  logic [ROLLW-1:0]     w_adr,
  input  logic [WGW-1:0]       w_data,
  output logic                 wr_drop,
  input  logic [1:0]           rb_sel,
  input  logic [ROLLW-1:0]     rb_adr,
  output logic [WGW-1:0]       rb_data,
  input  logic [NCH-1:0]       lk_vld,
  input  logic [NCH-1:0]       lk_even,
  input  logic [NCH*ROLLW-1:0] lk_roll,
  output logic [NCH-1:0]       out_vld,
  output logic [NCH*WGW-1:0]   out_wg_lo,
  output logic [NCH*WGW-1:0]   out_wg_hi,
  output logic [NCH-1:0]       out_inv
);

  localparam int DEPTH = 1 << ROLLW;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOAD = 1'b1;

  // Table order: odd_low, odd_high, even_low, even_high
  localparam logic [7:0] DEF [4][8] = '{
    '{8'd37, 8'd31, 8'd27, 8'd22, 8'd19, 8'd15, 8'd11, 8'd8},
    '{8'd47, 8'd44, 8'd38, 8'd33, 8'd28, 8'd23, 8'd19, 8'd15},
    '{8'd37, 8'd31, 8'd27, 8'd22, 8'd17, 8'd13, 8'd10, 8'd6},
    '{8'd47, 8'd44, 8'd38, 8'd32, 8'd27, 8'd22, 8'd17, 8'd14}
  };

  logic [0:0]       state;
  logic [ROLLW-1:0] ptr;
  logic [WGW-1:0]   tbl [4][DEPTH];

  logic [NCH-1:0]       s1_vld;
  logic [NCH-1:0]       s1_even;
  logic [NCH*ROLLW-1:0] s1_roll;
  logic [WGW-1:0]       rd_lo [NCH];
  logic [WGW-1:0]       rd_hi [NCH];

  function automatic logic [WGW-1:0] dflt(input logic [1:0] sel, input logic [ROLLW-1:0] adr);
    logic [7:0] v;
    v = '0;
    if (int'(adr) < 8) v = DEF[sel][3'(adr)];
    return WGW'(v);
  endfunction

  assign busy = (state == S_LOAD);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_LOAD;
      ptr   <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (reload) begin
            ptr <= '0;
          end else if (ptr == ROLLW'(DEPTH - 1)) begin
            state <= S_IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          if (reload) begin
            state <= S_LOAD;
            ptr   <= '0;
          end
        end
      endcase
    end
  end

  // Table storage is not reset; the load FSM fills it after every reset.
  always_ff @(posedge clock) begin
    if (state == S_LOAD) begin
      for (int t = 0; t < 4; t++) tbl[t][ptr] <= dflt(2'(t), ptr);
    end else if (wen) begin
      tbl[w_sel][w_adr] <= w_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_drop <= 1'b0;
      rb_data <= '0;
    end else begin
      wr_drop <= wen & busy;
      rb_data <= tbl[rb_sel][rb_adr];
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      rd_lo[i] = tbl[{s1_even[i], 1'b0}][s1_roll[i*ROLLW +: ROLLW]];
      rd_hi[i] = tbl[{s1_even[i], 1'b1}][s1_roll[i*ROLLW +: ROLLW]];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_vld    <= '0;
      s1_even   <= '0;
      s1_roll   <= '0;
      out_vld   <= '0;
      out_wg_lo <= '0;
      out_wg_hi <= '0;
      out_inv   <= '0;
    end else begin
      s1_vld  <= lk_vld & {NCH{~busy}};
      s1_even <= lk_even;
      s1_roll <= lk_roll;
      out_vld <= s1_vld;
      for (int i = 0; i < NCH; i++) begin
        // Data holds its last value on idle channels
        if (s1_vld[i]) begin
          out_wg_lo[i*WGW +: WGW] <= rd_lo[i];
          out_wg_hi[i*WGW +: WGW] <= rd_hi[i];
        end
        out_inv[i] <= s1_vld[i] & (rd_lo[i] > rd_hi[i]);
      end
    end
  end

endmodule

// File: tb/tb_gem_roll_to_csc_wg_lut_mch.sv
// tb/tb_gem_roll_to_csc_wg_lut_mch.sv - self-checking bench for gem_roll_to_csc_wg_lut_mch
// Directed steps followed by a randomized phase checked against a table model.
module tb_gem_roll_to_csc_wg_lut_mch;

  localparam int ROLLW = 3;
  localparam int WGW   = 7;
  localparam int NCH   = 4;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 reload = 1'b0;
  logic                 busy;
  logic                 wen = 1'b0;
  logic [1:0]           w_sel = '0;
  logic [ROLLW-1:0]     w_adr = '0;
  logic [WGW-1:0]       w_data = '0;
  logic                 wr_drop;
  logic [1:0]           rb_sel = '0;
  logic [ROLLW-1:0]     rb_adr = '0;
  logic [WGW-1:0]       rb_data;
  logic [NCH-1:0]       lk_vld = '0;
  logic [NCH-1:0]       lk_even = '0;
  logic [NCH*ROLLW-1:0] lk_roll = '0;
  logic [NCH-1:0]       out_vld;
  logic [NCH*WGW-1:0]   out_wg_lo;
  logic [NCH*WGW-1:0]   out_wg_hi;
  logic [NCH-1:0]       out_inv;

  int tests = 0;
  int fails = 0;

  int dtab [4][8] = '{
    '{37, 31, 27, 22, 19, 15, 11, 8},
    '{47, 44, 38, 33, 28, 23, 19, 15},
    '{37, 31, 27, 22, 17, 13, 10, 6},
    '{47, 44, 38, 32, 27, 22, 17, 14}
  };
  int model [4][8];

  gem_roll_to_csc_wg_lut_mch #(.ROLLW(ROLLW), .WGW(WGW), .NCH(NCH)) dut (
    .clock(clock), .reset(reset), .reload(reload), .busy(busy),
    .wen(wen), .w_sel(w_sel), .w_adr(w_adr), .w_data(w_data), .wr_drop(wr_drop),
    .rb_sel(rb_sel), .rb_adr(rb_adr), .rb_data(rb_data),
    .lk_vld(lk_vld), .lk_even(lk_even), .lk_roll(lk_roll),
    .out_vld(out_vld), .out_wg_lo(out_wg_lo), .out_wg_hi(out_wg_hi), .out_inv(out_inv)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic req(input int ch, input logic ev, input int roll);
    lk_vld[ch] = 1'b1;
    lk_even[ch] = ev;
    lk_roll[ch*ROLLW +: ROLLW] = ROLLW'(roll);
  endtask

  function automatic logic [31:0] lo_of(input int ch);
    return 32'(out_wg_lo[ch*WGW +: WGW]);
  endfunction

  function automatic logic [31:0] hi_of(input int ch);
    return 32'(out_wg_hi[ch*WGW +: WGW]);
  endfunction

  task automatic count_busy(input string tag);
    for (int c = 0; c < 9; c++) begin
      chk(tag, 32'(busy), 32'(c < 8));
      if (c < 8) step();
    end
  endtask

  // Randomized-phase state
  logic          pw_v = 1'b0;
  int            pw_s, pw_a, pw_d;
  logic [NCH-1:0] pv = '0, pe = '0;
  int            pr [NCH];
  logic [NCH-1:0] e_vld = '0, e_inv = '0, n_vld, n_inv;
  int            e_lo [NCH], e_hi [NCH], h_lo [NCH], h_hi [NCH];
  int            rb_exp = 0;

  initial begin
    step();
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_wr_drop", 32'(wr_drop), 32'd0);
    chk("reset_rb_data", 32'(rb_data), 32'd0);
    chk("reset_out_vld", 32'(out_vld), 32'd0);
    chk("reset_out_lo", 32'(out_wg_lo), 32'd0);
    chk("reset_out_hi", 32'(out_wg_hi), 32'd0);
    chk("reset_out_inv", 32'(out_inv), 32'd0);
    reset = 1'b0;

    // Initial load: lookup and write issued while busy must be discarded
    for (int c = 1; c <= 9; c++) begin
      if (c == 3) req(0, 1'b0, 4);
      if (c == 4) lk_vld = '0;
      if (c == 5) begin wen = 1'b1; w_sel = 2'd1; w_adr = '0; w_data = 7'd5; end
      if (c == 6) wen = 1'b0;
      step();
      chk("busy_after_reset", 32'(busy), 32'(c < 8));
      if (c == 4 || c == 5) chk("busy_lookup_dropped", 32'(out_vld), 32'd0);
      if (c == 5) chk("wr_drop_pulse", 32'(wr_drop), 32'd1);
      if (c == 6) chk("wr_drop_end", 32'(wr_drop), 32'd0);
    end
    rb_sel = 2'd1; rb_adr = 3'd0;
    step();
    chk("rb_odd_high_0", 32'(rb_data), 32'd47);

    req(0, 1'b0, 4);
    step();
    lk_vld = '0;
    step();
    chk("lk_odd4_vld", 32'(out_vld), 32'h1);
    chk("lk_odd4_lo", lo_of(0), 32'd19);
    chk("lk_odd4_hi", hi_of(0), 32'd28);
    chk("lk_odd4_inv", 32'(out_inv), 32'd0);

    // Write lands in the same cycle as the stage-2 read of an earlier request
    req(2, 1'b1, 7);
    step();
    wen = 1'b1; w_sel = 2'd2; w_adr = 3'd7; w_data = 7'd50;
    step();
    wen = 1'b0; lk_vld = '0;
    chk("coll_old_vld", 32'(out_vld), 32'h4);
    chk("coll_old_lo", lo_of(2), 32'd6);
    chk("coll_old_hi", hi_of(2), 32'd14);
    chk("coll_old_inv", 32'(out_inv), 32'd0);
    step();
    chk("coll_new_vld", 32'(out_vld), 32'h4);
    chk("coll_new_lo", lo_of(2), 32'd50);
    chk("coll_new_hi", hi_of(2), 32'd14);
    chk("coll_new_inv", 32'(out_inv), 32'h4);
    step();
    chk("hold_vld", 32'(out_vld), 32'd0);
    chk("hold_lo", lo_of(2), 32'd50);
    chk("hold_inv", 32'(out_inv), 32'd0);

    // All channels on roll 0, mixed parity, back-to-back
    lk_vld = 4'hF; lk_even = 4'b1010; lk_roll = '0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k >= 1) begin
        chk("b2b_vld", 32'(out_vld), 32'hF);
        chk("b2b_inv", 32'(out_inv), 32'd0);
        for (int ch = 0; ch < NCH; ch++) begin
          chk("b2b_lo", lo_of(ch), 32'd37);
          chk("b2b_hi", hi_of(ch), 32'd47);
        end
      end
    end
    lk_vld = '0;

    // Software reload restores defaults
    wen = 1'b1; w_sel = 2'd0; w_adr = 3'd1; w_data = 7'd99;
    step();
    wen = 1'b0; rb_sel = 2'd0; rb_adr = 3'd1;
    step();
    chk("rb_overwrite", 32'(rb_data), 32'd99);
    reload = 1'b1;
    step();
    reload = 1'b0;
    count_busy("busy_reload");
    step();
    chk("rb_after_reload", 32'(rb_data), 32'd31);

    // Reset in the middle of a load
    reload = 1'b1;
    step();
    reload = 1'b0;
    repeat (4) step();
    chk("midload_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("midreset_lo", 32'(out_wg_lo), 32'd0);
    chk("midreset_hi", 32'(out_wg_hi), 32'd0);
    chk("midreset_rb", 32'(rb_data), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd1);
    step();
    reset = 1'b0;
    count_busy("busy_midreset");

    // Randomized traffic against the table model
    model = dtab;
    for (int ch = 0; ch < NCH; ch++) begin
      h_lo[ch] = 0; h_hi[ch] = 0; pr[ch] = 0; e_lo[ch] = 0; e_hi[ch] = 0;
    end
    for (int k = 0; k < 300; k++) begin
      if (pw_v) model[pw_s][pw_a] = pw_d;
      n_vld = pv;
      for (int ch = 0; ch < NCH; ch++) begin
        if (pv[ch]) begin
          h_lo[ch] = model[pe[ch] ? 2 : 0][pr[ch]];
          h_hi[ch] = model[pe[ch] ? 3 : 1][pr[ch]];
        end
        n_inv[ch] = pv[ch] && (h_lo[ch] > h_hi[ch]);
      end
      if (k >= 2) begin
        chk("rnd_vld", 32'(out_vld), 32'(e_vld));
        chk("rnd_inv", 32'(out_inv), 32'(e_inv));
        chk("rnd_rb", 32'(rb_data), 32'(rb_exp));
        for (int ch = 0; ch < NCH; ch++) begin
          chk("rnd_lo", lo_of(ch), 32'(e_lo[ch]));
          chk("rnd_hi", hi_of(ch), 32'(e_hi[ch]));
        end
      end
      e_vld = n_vld;
      e_inv = n_inv;
      for (int ch = 0; ch < NCH; ch++) begin
        e_lo[ch] = h_lo[ch];
        e_hi[ch] = h_hi[ch];
      end

      lk_vld = NCH'($urandom);
      lk_even = NCH'($urandom);
      for (int ch = 0; ch < NCH; ch++) begin
        pr[ch] = $urandom_range(0, 7);
        lk_roll[ch*ROLLW +: ROLLW] = ROLLW'(pr[ch]);
      end
      pv = lk_vld;
      pe = lk_even;
      pw_v = 1'($urandom_range(0, 1));
      pw_s = $urandom_range(0, 3);
      pw_a = $urandom_range(0, 7);
      pw_d = $urandom_range(0, 127);
      wen = pw_v; w_sel = 2'(pw_s); w_adr = ROLLW'(pw_a); w_data = WGW'(pw_d);
      rb_sel = 2'($urandom_range(0, 3));
      rb_adr = ROLLW'($urandom_range(0, 7));
      rb_exp = model[rb_sel][rb_adr];
      step();
    end
    wen = 1'b0;
    lk_vld = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
